// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Stall/flush sequencer for the five-stage in-order core; redirects
//            raised while memory is stalled are parked and replayed on ack.
//            Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dest,
    input  logic        jmp,
    input  logic [31:0] jmp_addr,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        bubble_e,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cycles,
    output logic [31:0] perf_redirects
`endif
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_flush    = 2'd1;
    localparam logic [1:0] c_st_mem_wait = 2'd2;

    localparam logic [2:0] c_flush_last = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] c_to_last    = 8'(MEM_TIMEOUT - 1);
    localparam bit         c_to_en      = (MEM_TIMEOUT != 0);

    logic [1:0]  r_state;
    logic [2:0]  r_flush_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_jmp_pending;
    logic [31:0] r_pending_addr;
    logic        r_redirect;

    logic w_mem_stall;
    logic w_hz;

    assign w_mem_stall = mem_req & ~mem_ack;
    assign w_hz = dec_valid & ex_valid & ex_is_load & (ex_dest != 5'd0) &
                  ((dec_rs1_used & (dec_rs1 == ex_dest)) |
                   (dec_rs2_used & (dec_rs2 == ex_dest)));

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        bubble_e  = 1'b0;
        flush_fd  = 1'b0;
        flush_de  = 1'b0;
        pc_load   = 1'b0;
        pc_target = 32'd0;
        if (w_mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (jmp) begin
                        pc_load   = 1'b1;
                        pc_target = jmp_addr;
                        flush_fd  = 1'b1;
                        flush_de  = 1'b1;
                    end else if (w_hz) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        bubble_e = 1'b1;
                    end
                end
                c_st_flush: begin
                    flush_fd = 1'b1;
                    flush_de = 1'b1;
                    // First flush cycle after a parked redirect issues the PC load
                    if (r_redirect) begin
                        pc_load   = 1'b1;
                        pc_target = r_pending_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_err = c_to_en && (r_state == c_st_mem_wait) && w_mem_stall &&
                     (r_wait_cnt == c_to_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_run;
            r_flush_cnt    <= 3'd0;
            r_wait_cnt     <= 8'd0;
            r_jmp_pending  <= 1'b0;
            r_pending_addr <= 32'd0;
            r_redirect     <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    r_wait_cnt <= 8'd0;
                    r_redirect <= 1'b0;
                    if (w_mem_stall) begin
                        r_state <= c_st_mem_wait;
                        if (jmp) begin
                            r_jmp_pending  <= 1'b1;
                            r_pending_addr <= jmp_addr;
                        end
                    end else if (jmp && (c_flush_last != 3'd0)) begin
                        r_state     <= c_st_flush;
                        r_flush_cnt <= 3'd1;
                    end
                end
                c_st_flush: begin
                    // A memory stall freezes the flush sequence in place
                    if (!w_mem_stall) begin
                        r_redirect <= 1'b0;
                        if (r_flush_cnt >= c_flush_last) begin
                            r_state     <= c_st_run;
                            r_flush_cnt <= 3'd0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 3'd1;
                        end
                    end
                end
                c_st_mem_wait: begin
                    if (w_mem_stall) begin
                        if (jmp && !r_jmp_pending) begin
                            r_jmp_pending  <= 1'b1;
                            r_pending_addr <= jmp_addr;
                        end
                        if (c_to_en && (r_wait_cnt == c_to_last))
                            r_wait_cnt <= 8'd0;
                        else
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                    end else begin
                        r_wait_cnt <= 8'd0;
                        if (r_jmp_pending || jmp) begin
                            r_state        <= c_st_flush;
                            r_flush_cnt    <= 3'd0;
                            r_redirect     <= 1'b1;
                            r_jmp_pending  <= 1'b0;
                            r_pending_addr <= r_jmp_pending ? r_pending_addr : jmp_addr;
                        end else begin
                            r_state <= c_st_run;
                        end
                    end
                end
                default: r_state <= c_st_run;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
            r_perf_redir <= 32'd0;
        end else begin
            if ((stall_f | stall_d | stall_e | stall_m) && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (flush_fd && (r_perf_flush != 32'hFFFF_FFFF))
                r_perf_flush <= r_perf_flush + 32'd1;
            if (pc_load && (r_perf_redir != 32'hFFFF_FFFF))
                r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_cycles = r_perf_flush;
    assign perf_redirects    = r_perf_redir;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Cycle-table stimulus with a queue scoreboard for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam logic [8:0] c_sf  = 9'h100;
    localparam logic [8:0] c_sd  = 9'h080;
    localparam logic [8:0] c_se  = 9'h040;
    localparam logic [8:0] c_sm  = 9'h020;
    localparam logic [8:0] c_be  = 9'h010;
    localparam logic [8:0] c_ffd = 9'h008;
    localparam logic [8:0] c_fde = 9'h004;
    localparam logic [8:0] c_pl  = 9'h002;
    localparam logic [8:0] c_me  = 9'h001;
    localparam logic [8:0] c_st4 = c_sf | c_sd | c_se | c_sm;
    localparam logic [8:0] c_lu  = c_sf | c_sd | c_be;
    localparam logic [8:0] c_fl  = c_ffd | c_fde;

    typedef struct {
        string       name;
        logic        jmp;
        logic [31:0] addr;
        logic        mreq;
        logic        mack;
        int          hzsel;
        logic [8:0]  ctl;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [31:0] tgt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_dest;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        stall_f, stall_d, stall_e, stall_m, bubble_e;
    logic        flush_fd, flush_de, pc_load, mem_err;
    logic [31:0] pc_target;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_redirects;
`endif

    logic [8:0] w_act;
    assign w_act = {stall_f, stall_d, stall_e, stall_m, bubble_e,
                    flush_fd, flush_de, pc_load, mem_err};

    int   errors = 0;
    int   checks = 0;
    vec_t tv[$];
    exp_t exp_q[$];
    exp_t e;

    pipeline_hazard_controller #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_dest      (ex_dest),
        .jmp          (jmp),
        .jmp_addr     (jmp_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .bubble_e     (bubble_e),
        .flush_fd     (flush_fd),
        .flush_de     (flush_de),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .mem_err      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
       ,.perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic add(input string n, input logic j, input logic [31:0] a,
                       input logic mq, input logic mk, input int hz,
                       input logic [8:0] ctl, input logic [31:0] tgt);
        vec_t v;
        v.name = n; v.jmp = j; v.addr = a; v.mreq = mq; v.mack = mk;
        v.hzsel = hz; v.ctl = ctl; v.tgt = tgt;
        tv.push_back(v);
    endtask

    // hz: 0 none, 1 rs2 load-use, 2 x0 match, 3 rs1 load-use, 4 rs1 unused, 5 not a load
    task automatic apply(input vec_t v);
        dec_valid    = (v.hzsel != 0);
        ex_valid     = (v.hzsel != 0);
        ex_is_load   = (v.hzsel != 0) && (v.hzsel != 5);
        dec_rs1      = 5'd0;
        dec_rs2      = 5'd0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        ex_dest      = 5'd0;
        case (v.hzsel)
            1, 5: begin dec_rs2 = 5'd5; dec_rs2_used = 1'b1; ex_dest = 5'd5; end
            2:    begin dec_rs2 = 5'd0; dec_rs2_used = 1'b1; ex_dest = 5'd0; end
            3:    begin dec_rs1 = 5'd7; dec_rs1_used = 1'b1; ex_dest = 5'd7; end
            4:    begin dec_rs1 = 5'd7; dec_rs1_used = 1'b0; ex_dest = 5'd7; end
            default: ;
        endcase
        jmp      = v.jmp;
        jmp_addr = v.addr;
        mem_req  = v.mreq;
        mem_ack  = v.mack;
    endtask

    task automatic check_ctl(input string n, input logic [8:0] exp_ctl);
        checks++;
        if (w_act !== exp_ctl) begin
            errors++;
            $display("FAIL %s: ctl got %b expected %b", n, w_act, exp_ctl);
        end
    endtask

    task automatic check_word(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp_v);
        end
    endtask

    initial begin
        vec_t idle;
        idle.name = "idle"; idle.jmp = 0; idle.addr = 0; idle.mreq = 0; idle.mack = 0;
        idle.hzsel = 0; idle.ctl = 0; idle.tgt = 0;
        rst_n = 1'b0;
        apply(idle);

        add("idle",           0, 32'h0,   0, 0, 0, 9'h0,        32'h0);
        add("jmp_t",          1, 32'h100, 0, 0, 0, c_fl | c_pl, 32'h100);
        add("jmp_flush2",     0, 32'h0,   0, 0, 0, c_fl,        32'h0);
        add("jmp_done",       0, 32'h0,   0, 0, 0, 9'h0,        32'h0);
        add("lu_rs2",         0, 32'h0,   0, 0, 1, c_lu,        32'h0);
        add("lu_x0",          0, 32'h0,   0, 0, 2, 9'h0,        32'h0);
        add("lu_rs1",         0, 32'h0,   0, 0, 3, c_lu,        32'h0);
        add("lu_rs1_unused",  0, 32'h0,   0, 0, 4, 9'h0,        32'h0);
        add("lu_notload",     0, 32'h0,   0, 0, 5, 9'h0,        32'h0);
        add("jmp_over_hz",    1, 32'h300, 0, 0, 1, c_fl | c_pl, 32'h300);
        add("flush_hz_jmp",   1, 32'h500, 0, 0, 1, c_fl,        32'h0);
        add("flush_end",      0, 32'h0,   0, 0, 0, 9'h0,        32'h0);
        add("mw_entry",       0, 32'h0,   1, 0, 0, c_st4,       32'h0);
        add("mw_jmp",         1, 32'h200, 1, 0, 0, c_st4,       32'h0);
        add("mw_wait",        0, 32'h0,   1, 0, 0, c_st4,       32'h0);
        add("mw_ack",         0, 32'h0,   1, 1, 0, 9'h0,        32'h0);
        add("mw_redirect",    0, 32'h0,   0, 0, 0, c_fl | c_pl, 32'h200);
        add("mw_flush2",      0, 32'h0,   0, 0, 0, c_fl,        32'h0);
        add("mw_done",        0, 32'h0,   0, 0, 0, 9'h0,        32'h0);
        add("all3",           1, 32'h400, 1, 0, 1, c_st4,       32'h0);
        add("all3_ack",       0, 32'h0,   1, 1, 0, 9'h0,        32'h0);
        add("all3_redirect",  0, 32'h0,   0, 0, 0, c_fl | c_pl, 32'h400);
        add("all3_flush2",    0, 32'h0,   0, 0, 0, c_fl,        32'h0);
        add("all3_done",      0, 32'h0,   0, 0, 0, 9'h0,        32'h0);
        add("to_entry",       0, 32'h0,   1, 0, 0, c_st4,       32'h0);
        for (int k = 1; k <= 8; k++)
            add($sformatf("to_wait%0d", k), 0, 32'h0, 1, 0, 0,
                c_st4 | (((k == 4) || (k == 8)) ? c_me : 9'h0), 32'h0);
        add("to_ack",         0, 32'h0,   1, 1, 0, 9'h0,        32'h0);
        add("to_done",        0, 32'h0,   0, 0, 0, 9'h0,        32'h0);

        // Reset behaviour, including an asynchronous abort of a flush
        repeat (2) @(negedge clk);
        check_ctl("reset_outputs", 9'h0);
        check_word("reset_target", pc_target, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        jmp = 1'b1; jmp_addr = 32'h80;
        @(negedge clk);
        check_ctl("pre_reset_jmp", c_fl | c_pl);
        @(posedge clk); #1;
        apply(idle);
        @(negedge clk);
        check_ctl("pre_reset_flush", c_fl);
        #1 rst_n = 1'b0;
        #1 check_ctl("async_reset_mid_flush", 9'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_ctl("post_reset_run", 9'h0);

        for (int i = 0; i < tv.size(); i++) begin
            exp_t x;
            @(posedge clk); #1;
            apply(tv[i]);
            x.name = tv[i].name; x.ctl = tv[i].ctl; x.tgt = tv[i].tgt;
            exp_q.push_back(x);
            @(negedge clk);
            e = exp_q.pop_front();
            check_ctl(e.name, e.ctl);
            if (e.ctl[1])
                check_word({e.name, "_target"}, pc_target, e.tgt);
`ifdef HAZARD_PERF_CNT_EN
            if (i == 3) begin
                check_word("perf_redirects", perf_redirects, 32'd1);
                check_word("perf_flush_cycles", perf_flush_cycles, 32'd2);
                check_word("perf_stall_cycles", perf_stall_cycles, 32'd0);
            end
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the in-order RISC-V core pipeline (fetch, decode, execute, memory, writeback).
- Consumes the executor's branch-resolution outputs (jmp, jmp_addr), decode-stage register usage, execute-stage load info and the data-memory handshake.
- Drives per-stage stall/flush controls and the PC redirect.
- Guarantees redirects are never lost while memory is stalled.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_fd/flush_de stay high per redirect (1..7).
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_err pulses (0 = no timeout).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode stage holds a valid instruction
- dec_rs1  in  5  decode rs1 index
- dec_rs2  in  5  decode rs2 index
- dec_rs1_used  in  1  rs1 actually read
- dec_rs2_used  in  1  rs2 actually read
- ex_valid  in  1  execute stage holds a valid instruction
- ex_is_load  in  1  execute instruction is a LOAD
- ex_dest  in  5  execute destination register
- jmp  in  1  executor redirect request
- jmp_addr  in  32  executor redirect target
- mem_req  in  1  memory stage issues access
- mem_ack  in  1  data memory completes access
- stall_f  out  1  hold PC/fetch register
- stall_d  out  1  hold decode register
- stall_e  out  1  hold execute register
- stall_m  out  1  hold memory register
- bubble_e  out  1  inject NONE into execute
- flush_fd  out  1  kill fetch→decode instruction
- flush_de  out  1  kill decode→execute instruction
- pc_load  out  1  one-cycle PC redirect strobe
- pc_target  out  32  redirect address
- mem_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, rst_n=0): state=RUN; all outputs 0; pc_target=0; counters and pending flags cleared. Reset mid-flush or mid-wait aborts the sequence immediately.
- FSM states:
  - RUN→FLUSH on jmp.
  - RUN→MEM_WAIT on mem_req&!mem_ack.
  - FLUSH→RUN after FLUSH_CYCLES total flush cycles.
  - MEM_WAIT→RUN on mem_ack with no pending jump.
  - MEM_WAIT→FLUSH on mem_ack with jmp_pending.
- Memory-stall priority: mem_req&!mem_ack in any state makes stall_f/d/e/m=1 combinationally in that cycle (MEM_WAIT entry cycle included) and overrides everything else.
- Redirect in RUN:
  - Cycle t (jmp=1, no mem stall): pc_load=1, pc_target=jmp_addr (combinational), flush_fd=flush_de=1.
  - FLUSH holds flush_fd/flush_de=1 for FLUSH_CYCLES-1 further cycles; pc_load only in cycle t.
  - Redirect pre-empts load-use stall (stall_f/d, bubble_e = 0 while flushing).
- Jump during MEM_WAIT: latch jmp_pending=1, pending_addr=jmp_addr; no flush/pc_load while stalled. On the ack cycle, stalls drop and the redirect sequence starts next cycle using pending_addr; jmp_pending cleared. jmp repeating during FLUSH is ignored.
- Load-use hazard: hz = dec_valid & ex_valid & ex_is_load & ex_dest≠0 & ((dec_rs1_used & dec_rs1==ex_dest) | (dec_rs2_used & dec_rs2==ex_dest)).
  - In RUN with no jmp and no mem stall, hz gives stall_f=stall_d=bubble_e=1 for exactly that cycle (combinational).
  - The following cycle re-evaluates (load has moved on, so hz=0).
  - x0 never hazards.
- Timeout: 8-bit counter increments each MEM_WAIT cycle and resets on leaving it. On reaching MEM_TIMEOUT (≠0), mem_err pulses 1 cycle, counter restarts, state stays MEM_WAIT.
- Simultaneous mem stall + hz + jmp in RUN: mem stall wins; jmp latched pending; hz ignored.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0], perf_flush_cycles[31:0], perf_redirects[31:0]. These count cycles with any stall_* high, cycles with flush_fd high, and pc_load pulses. Saturating at 0xFFFFFFFF; async reset to 0.
- Undefined: no such ports or logic; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 asserted mid-FLUSH → all outputs 0 asynchronously; after release, state RUN, no pc_load.
- jmp=1, jmp_addr=0x0000_0100 for one cycle → pc_load=1 and pc_target=0x100 that cycle; flush_fd/flush_de high exactly 2 cycles (FLUSH_CYCLES=2).
- ex_is_load=1, ex_dest=5, dec_rs2=5, dec_rs2_used=1 → stall_f/stall_d/bubble_e=1 one cycle. Repeat with ex_dest=0 → no stall.
- mem_req=1, mem_ack low 3 cycles, jmp=1 (addr 0x200) during wait → stall_* high 3 cycles, no pc_load. Cycle after ack: pc_load=1, pc_target=0x200.
- MEM_TIMEOUT=4, mem_ack never → mem_err pulses after 4 and 8 wait cycles; stalls remain high.
- With HAZARD_PERF_CNT_EN, after the jump test → perf_redirects=1, perf_flush_cycles=2.
